// File: rtl/capiano_pkg.sv
// ============================================================================
// Module      : capiano_pkg
// Description : Shared constants and FSM state type for the key reporter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package capiano_pkg;

  localparam int KEY_COUNT  = 40;
  localparam int DEBOUNCE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } kr_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Single-key debouncer, samples raw input on tick strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import capiano_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam logic [DEBOUNCE_W-1:0] c_LIMIT = DEBOUNCE_W'(DEBOUNCE);
  localparam logic [DEBOUNCE_W-1:0] c_MAX   = '1;

  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("DEBOUNCE must be in 1..15");
  end

  logic [DEBOUNCE_W-1:0] r_cnt;
  logic [DEBOUNCE_W-1:0] w_cnt_inc;
  logic                  r_stable;

  assign w_cnt_inc = (r_cnt == c_MAX) ? r_cnt : r_cnt + 1'b1;
  assign stable    = r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (tick) begin
      if (raw == r_stable) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == c_LIMIT) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_reporter.sv
// ============================================================================
// Module      : key_reporter
// Description : Debounced key-change reporter driving the UART send handshake.
//               Optional heartbeat resend via KEY_REPORT_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_reporter
  import capiano_pkg::*;
#(
  parameter int KEYS      = KEY_COUNT,
  parameter int DEBOUNCE  = 3,
  parameter int HEARTBEAT = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic [KEYS-1:0] key_down,
  input  logic            send_done,
  output logic            send,
  output logic [KEYS-1:0] data,
  output logic [KEYS-1:0] stable,
  output logic            dirty
);

  if (HEARTBEAT < 1) begin : g_bad_heartbeat
    $error("HEARTBEAT must be >= 1");
  end

  logic [KEYS-1:0] w_stable;
  logic [KEYS-1:0] r_stable_prev;
  logic [KEYS-1:0] r_data;
  logic            r_chg;
  logic            r_dirty;
  logic            w_start;
  logic            w_hb_fire;
  kr_state_t       r_state;
  kr_state_t       w_state_next;

  for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .tick   (frame_tick),
      .raw    (key_down[gi]),
      .stable (w_stable[gi])
    );
  end

`ifdef KEY_REPORT_HEARTBEAT_EN
  localparam int c_HB_W = $clog2(HEARTBEAT + 1);

  logic [c_HB_W-1:0] r_hb_cnt;

  // Counter parks at HEARTBEAT until a report start clears it.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_hb_cnt <= '0;
    end else if (frame_tick && (r_hb_cnt != c_HB_W'(HEARTBEAT))) begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
    end
  end

  assign w_hb_fire = (r_state == IDLE) && (r_hb_cnt == c_HB_W'(HEARTBEAT));
`else
  assign w_hb_fire = 1'b0;
`endif

  assign send   = (r_state == REQ);
  assign data   = r_data;
  assign stable = w_stable;
  assign dirty  = r_dirty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_stable_prev <= '0;
      r_chg         <= 1'b0;
      r_dirty       <= 1'b0;
      r_data        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_stable_prev <= w_stable;
      r_chg         <= (w_stable != r_stable_prev);
      // Report start snapshots the latest stable state and absorbs any queued change.
      if (w_start) begin
        r_data  <= w_stable;
        r_dirty <= 1'b0;
      end else if ((r_chg && (r_state != IDLE)) || w_hb_fire) begin
        r_dirty <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_chg || r_dirty) begin
          w_start      = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (send_done) w_state_next = RELEASE;
      end
      RELEASE: begin
        if (!send_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_key_reporter.sv
// ============================================================================
// Module      : tb_key_reporter
// Description : Directed bench for key_reporter (heartbeat case under
//               KEY_REPORT_HEARTBEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_reporter;

  localparam int KEYS = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic [KEYS-1:0] key_down;
  logic            send_done;
  logic            send;
  logic [KEYS-1:0] data;
  logic [KEYS-1:0] stable;
  logic            dirty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [KEYS-1:0] key;
    int              ticks;
    logic [KEYS-1:0] exp_stable;
    bit              exp_report;
  } vec_t;

  vec_t vecs [8];

  key_reporter #(
    .KEYS      (KEYS),
    .DEBOUNCE  (3),
    .HEARTBEAT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .key_down   (key_down),
    .send_done  (send_done),
    .send       (send),
    .data       (data),
    .stable     (stable),
    .dirty      (dirty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [KEYS-1:0] act, input logic [KEYS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic wait_send(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (send === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic ack();
    bit dropped;
    dropped   = 1'b0;
    send_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (send === 1'b0) begin
        dropped = 1'b1;
        break;
      end
    end
    check("ack_drop", dropped, 1'b1);
    send_done = 1'b0;
    step();
    step();
  endtask

  initial begin
    bit seen;
    bit any_send;
    int n;

    vecs[0] = '{key: 40'h1,             ticks: 2, exp_stable: 40'h0,             exp_report: 1'b0};
    vecs[1] = '{key: 40'h0,             ticks: 3, exp_stable: 40'h0,             exp_report: 1'b0};
    vecs[2] = '{key: 40'h5,             ticks: 3, exp_stable: 40'h5,             exp_report: 1'b1};
    vecs[3] = '{key: 40'h4,             ticks: 3, exp_stable: 40'h4,             exp_report: 1'b1};
    vecs[4] = '{key: 40'h0,             ticks: 1, exp_stable: 40'h4,             exp_report: 1'b0};
    vecs[5] = '{key: 40'h0,             ticks: 2, exp_stable: 40'h0,             exp_report: 1'b1};
    vecs[6] = '{key: 40'hFF_FFFF_FFFF, ticks: 3, exp_stable: 40'hFF_FFFF_FFFF, exp_report: 1'b1};
    vecs[7] = '{key: 40'h0,             ticks: 3, exp_stable: 40'h0,             exp_report: 1'b1};

    rst        = 1'b1;
    frame_tick = 1'b0;
    key_down   = '0;
    send_done  = 1'b0;
    step();
    step();
    check("reset_send", send, 1'b0);
    check("reset_data", data, 40'h0);
    check("reset_stable", stable, 40'h0);
    check("reset_dirty", dirty, 1'b0);
    rst = 1'b0;
    step();

    // Press report with exact latency
    key_down = 40'h5;
    tick();
    tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("press_stable", stable, 40'h5);
    check("press_send_early0", send, 1'b0);
    step();
    check("press_send_early1", send, 1'b0);
    step();
    check("press_send", send, 1'b1);
    check("press_data", data, 40'h5);

    // Coalescing during REQ
    key_down = 40'h80_0000_0000;
    repeat (3) tick();
    key_down = 40'h80_0000_0001;
    repeat (3) tick();
    step();
    step();
    check("coal_dirty", dirty, 1'b1);
    check("coal_send_held", send, 1'b1);
    check("coal_data_held", data, 40'h5);

    // Release gating with send_done held high
    send_done = 1'b1;
    step();
    check("ack_send_fall", send, 1'b0);
    any_send = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (send !== 1'b0) any_send = 1'b1;
    end
    check("gate_no_send", any_send, 1'b0);
    send_done = 1'b0;
    step();
    check("gate_send_after_drop0", send, 1'b0);
    step();
    check("coal_send", send, 1'b1);
    check("coal_data", data, 40'h80_0000_0001);
    check("coal_dirty_clr", dirty, 1'b0);
    ack();
    any_send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (send !== 1'b0) any_send = 1'b1;
    end
    check("coal_single", any_send, 1'b0);

    // Reset mid-handshake
    key_down = 40'h3;
    repeat (3) tick();
    wait_send(seen);
    check("rst_pre_send", seen, 1'b1);
    check("rst_pre_data", data, 40'h3);
    rst = 1'b1;
    step();
    check("rst_mid_send", send, 1'b0);
    check("rst_mid_data", data, 40'h0);
    check("rst_mid_stable", stable, 40'h0);
    check("rst_mid_dirty", dirty, 1'b0);
    rst      = 1'b0;
    key_down = '0;
    step();

    // Table-driven debounce / report vectors
    for (int v = 0; v < 8; v++) begin
      key_down = vecs[v].key;
      repeat (vecs[v].ticks) tick();
      wait_send(seen);
      check($sformatf("vec%0d_report", v), seen, vecs[v].exp_report);
      if (seen) begin
        check($sformatf("vec%0d_data", v), data, vecs[v].exp_stable);
        ack();
      end
      check($sformatf("vec%0d_stable", v), stable, vecs[v].exp_stable);
    end

`ifdef KEY_REPORT_HEARTBEAT_EN
    key_down = 40'h2;
    repeat (3) tick();
    wait_send(seen);
    check("hb_change_report", seen, 1'b1);
    if (seen) ack();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      for (int t = 0; t < 10; t++) begin
        tick();
        n++;
        if (dirty === 1'b1 || send === 1'b1) break;
      end
      check($sformatf("hb%0d_ticks", r), n, 4);
      wait_send(seen);
      check($sformatf("hb%0d_report", r), seen, 1'b1);
      check($sformatf("hb%0d_data", r), data, 40'h2);
      if (seen) ack();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
